// File: rtl/cond_debounce.sv
// cond_debounce: three-channel switch/sensor debouncer.
// Each raw input passes through a two-flop synchroniser. A channel accepts a
// new level only after DEB_CYCLES consecutive synchronised samples that differ
// from its current output. chg pulses for one cycle whenever any output moves.
// Optional feature macro: COND_DEBOUNCE_EDGE_EN adds x1_rise/x2_rise/x3_rise,
// which are one-cycle pulses on each 0->1 transition of the matching output.
module cond_debounce #(
  parameter int DEB_CYCLES = 8,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sw1,
  input  logic sw2,
  input  logic sw3,
  output logic x1,
  output logic x2,
  output logic x3,
`ifdef COND_DEBOUNCE_EDGE_EN
  output logic x1_rise,
  output logic x2_rise,
  output logic x3_rise,
`endif
  output logic chg,
  output logic stable
);

  // The last count value before acceptance; reaching it with a still-differing
  // sample means this edge is the DEB_CYCLES-th consecutive differing sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       sw_vec;
  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       x;
  logic [2:0]       x_nxt;
  logic [CNT_W-1:0] cnt [3];

  assign sw_vec = {sw3, sw2, sw1};

  // Two-flop synchroniser for each raw input.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_vec;
      s2 <= s1;
    end
  end

  // Next debounced level: load the synchronised level once the count is full.
  always_comb begin
    x_nxt = x;
    for (int i = 0; i < 3; i++) begin
      if ((s2[i] != x[i]) && (cnt[i] == CNT_LAST)) begin
        x_nxt[i] = s2[i];
      end
    end
  end

  // Per-channel qualification counters; any agreeing sample discards progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == x[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Debounced levels and the shared change pulse, updated on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      x   <= '0;
      chg <= 1'b0;
    end else begin
      x   <= x_nxt;
      chg <= |(x_nxt ^ x);
    end
  end

`ifdef COND_DEBOUNCE_EDGE_EN
  logic [2:0] rise;

  // Rising-edge pulses, aligned with chg.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise <= '0;
    end else begin
      rise <= x_nxt & ~x;
    end
  end

  assign x1_rise = rise[0];
  assign x2_rise = rise[1];
  assign x3_rise = rise[2];
`endif

  assign x1 = x[0];
  assign x2 = x[1];
  assign x3 = x[2];

  assign stable = (cnt[0] == '0) && (cnt[1] == '0) && (cnt[2] == '0);

endmodule
